// File: rtl/led_pwm_scheduler_pkg.sv
// Shared types and defaults for the LED local-dimming PWM scheduler.
package led_dim_pkg;

  localparam int unsigned LED_ZONES    = 40;
  localparam int unsigned LED_PWM_BITS = 8;
  localparam int unsigned ZONE_AW      = $clog2(LED_ZONES);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND,
    HOLD
  } sched_state_e;

endpackage

// File: rtl/led_pwm_scheduler_zone_bank.sv
// Double-buffered per-zone duty storage: shadow is written by the dimming
// datapath, active is what the comparator array displays.
module led_zone_bank
  import led_dim_pkg::*;
#(
  parameter int unsigned ZONES    = LED_ZONES,
  parameter int unsigned PWM_BITS = LED_PWM_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [ZONE_AW-1:0]        wr_addr_i,
  input  logic [PWM_BITS-1:0]       wr_data_i,
  input  logic                      swap_i,
  output logic [ZONES*PWM_BITS-1:0] active_o
);

  logic [PWM_BITS-1:0] shadow_q [ZONES];
  logic [PWM_BITS-1:0] active_q [ZONES];

  // Swap copies the pre-write shadow, so a same-cycle write lands only in shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ZONES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ZONES; i++) begin
        if (swap_i) begin
          active_q[i] <= shadow_q[i];
        end
        if (wr_en_i && (wr_addr_i == ZONE_AW'(i))) begin
          shadow_q[i] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    active_o = '0;
    for (int unsigned i = 0; i < ZONES; i++) begin
      active_o[i*PWM_BITS +: PWM_BITS] = active_q[i];
    end
  end

endmodule

// File: rtl/led_pwm_scheduler.sv
// PWM slot sequencer for the 74HC595 LED chain: per slot, compares active
// zone duties against pwm_cnt and hands the on/off pattern to the shifter.
module led_pwm_scheduler
  import led_dim_pkg::*;
#(
  parameter int unsigned ZONES    = LED_ZONES,
  parameter int unsigned PWM_BITS = LED_PWM_BITS,
  parameter int unsigned SLOT_DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ZONE_AW-1:0]  wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                frame_swap,
  output logic [ZONES-1:0]    led_bits,
  output logic                led_valid,
  input  logic                led_ready,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_start,
  output logic                swap_done
);

  localparam int unsigned         TW         = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam logic [TW-1:0]       TIMER_LOAD = TW'(SLOT_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;

  sched_state_e               state_q;
  logic [TW-1:0]              timer_q;
  logic [PWM_BITS-1:0]        pwm_cnt_q;
  logic [ZONES-1:0]           led_bits_q;
  logic                       led_valid_q;
  logic                       swap_pending_q;
  logic                       swap_done_q;
  logic [ZONES-1:0]           cmp_d;
  logic                       boundary_d;
  logic                       swap_d;
  logic [ZONES*PWM_BITS-1:0]  active;

  led_zone_bank #(
    .ZONES    (ZONES),
    .PWM_BITS (PWM_BITS)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .swap_i    (swap_d),
    .active_o  (active)
  );

  always_comb begin
    cmp_d = '0;
    for (int unsigned i = 0; i < ZONES; i++) begin
      cmp_d[i] = active[i*PWM_BITS +: PWM_BITS] > pwm_cnt_q;
    end
  end

  // The wrap cycle is the last HOLD cycle of the top slot.
  assign boundary_d = (state_q == HOLD) && (timer_q == '0) && (pwm_cnt_q == CNT_MAX);
  assign swap_d     = boundary_d && (swap_pending_q || frame_swap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      pwm_cnt_q      <= '0;
      led_bits_q     <= '0;
      led_valid_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      swap_done_q <= swap_d;
      if (swap_d) begin
        swap_pending_q <= 1'b0;
      end else if (frame_swap) begin
        swap_pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= CALC;
          end
        end
        CALC: begin
          led_bits_q  <= cmp_d;
          led_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (led_ready) begin
            led_valid_q <= 1'b0;
            timer_q     <= TIMER_LOAD;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (timer_q == '0) begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            state_q   <= enable ? CALC : IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led_bits     = led_bits_q;
  assign led_valid    = led_valid_q;
  assign pwm_cnt      = pwm_cnt_q;
  assign swap_done    = swap_done_q;
  assign period_start = (state_q == CALC) && (pwm_cnt_q == '0);

endmodule

// File: tb/tb_led_pwm_scheduler.sv
// Self-checking bench for led_pwm_scheduler with a transaction-level duty model.
module tb_led_pwm_scheduler;

  localparam int ZN = 40;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        frame_swap = 1'b0;
  logic        led_ready = 1'b0;
  logic [39:0] led_bits;
  logic        led_valid;
  logic [7:0]  pwm_cnt;
  logic        period_start;
  logic        swap_done;

  int checks = 0;
  int errors = 0;

  // Model state: duties, pending swap, transfers seen, cycles left to the wrap.
  int shadow_m [ZN];
  int active_m [ZN];
  bit pending_m = 1'b0;
  int cnt_m = 0;
  int cd_m = 0;
  bit exp_swap = 1'b0;
  bit bnd_m, sw_m;

  logic        o_valid = 1'b0;
  logic        o_swap = 1'b0;
  logic [39:0] o_bits = '0;
  logic [7:0]  o_cnt = '0;

  led_pwm_scheduler #(
    .ZONES    (40),
    .PWM_BITS (8),
    .SLOT_DIV (SD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_swap   (frame_swap),
    .led_bits     (led_bits),
    .led_valid    (led_valid),
    .led_ready    (led_ready),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start),
    .swap_done    (swap_done)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] model_bits(input int c);
    logic [39:0] b;
    for (int i = 0; i < ZN; i++) b[i] = (active_m[i] > c);
    return b;
  endfunction

  always @(negedge clk) begin
    o_valid = led_valid;
    o_swap  = swap_done;
    o_bits  = led_bits;
    o_cnt   = pwm_cnt;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ZN; i++) begin
        shadow_m[i] = 0;
        active_m[i] = 0;
      end
      pending_m = 1'b0;
      cnt_m = 0;
      cd_m = 0;
      exp_swap = 1'b0;
    end else begin
      checks++;
      if (o_swap !== exp_swap) begin
        errors++;
        $display("FAIL mon_swap_done got %0b want %0b slot %0d", o_swap, exp_swap, cnt_m);
      end
      bnd_m = 1'b0;
      if (cd_m > 0) begin
        cd_m--;
        if (cd_m == 0) bnd_m = 1'b1;
      end
      if (o_valid && led_ready) begin
        checks++;
        if (o_cnt !== 8'(cnt_m)) begin
          errors++;
          $display("FAIL mon_pwm_cnt got %0d want %0d", o_cnt, cnt_m);
        end
        checks++;
        if (o_bits !== model_bits(cnt_m)) begin
          errors++;
          $display("FAIL mon_led_bits slot %0d got %h want %h", cnt_m, o_bits, model_bits(cnt_m));
        end
        if (cnt_m == 255) cd_m = SD;
        cnt_m = (cnt_m + 1) % 256;
      end
      sw_m = bnd_m && (pending_m || frame_swap);
      if (sw_m) begin
        active_m = shadow_m;
        pending_m = 1'b0;
      end else if (frame_swap) begin
        pending_m = 1'b1;
      end
      if (wr_en && (wr_addr < 6'd40)) shadow_m[wr_addr] = int'(wr_data);
      exp_swap = sw_m;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  task automatic do_write(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    frame_swap = 1'b1;
    @(negedge clk);
    frame_swap = 1'b0;
  endtask

  task automatic wait_swap_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (swap_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Counts on-slots of one zone over the next 256 transfers.
  task automatic collect_ones(input int zone, output int ones, output int slots);
    ones = 0;
    slots = 0;
    for (int i = 0; i < 1300 && slots < 256; i++) begin
      @(negedge clk);
      if (led_valid && led_ready) begin
        if (led_bits[zone]) ones++;
        slots++;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (led_bits !== '0)     begin errors++; $display("FAIL reset_led_bits got %h want 0", led_bits); end
    checks++; if (led_valid !== 1'b0)  begin errors++; $display("FAIL reset_led_valid got %b want 0", led_valid); end
    checks++; if (pwm_cnt !== '0)      begin errors++; $display("FAIL reset_pwm_cnt got %0d want 0", pwm_cnt); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start got %b want 0", period_start); end
    checks++; if (swap_done !== 1'b0)  begin errors++; $display("FAIL reset_swap_done got %b want 0", swap_done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count();
    enable = 1'b1;
    led_ready = 1'b1;
    @(negedge clk);
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL count_period_start got %b want 1", period_start); end
    checks++; if (pwm_cnt !== 8'd0) begin errors++; $display("FAIL count_cnt0 got %0d want 0", pwm_cnt); end
    for (int k = 1; k <= 3; k++) begin
      repeat (4) @(negedge clk);
      checks++; if (pwm_cnt !== 8'(k)) begin errors++; $display("FAIL count_cnt got %0d want %0d", pwm_cnt, k); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL count_no_period_start got %b want 0", period_start); end
      checks++; if (led_bits !== '0) begin errors++; $display("FAIL count_led_bits got %h want 0", led_bits); end
    end
  endtask

  task automatic test_swap();
    bit found;
    int k;
    do_write(0, 3);
    do_write(39, 255);
    do_write(5, 0);
    for (int z = 6; z < 39; z++) do_write(z, int'($urandom_range(0, 255)));
    for (int i = 0; i < 1200 && pwm_cnt != 8'd128; i++) @(negedge clk);
    pulse_swap();
    wait_swap_done(found);
    checks++; if (!found) begin errors++; $display("FAIL swap_done_seen got 0 want 1"); end
    checks++; if (pwm_cnt !== 8'd0) begin errors++; $display("FAIL swap_at_wrap cnt got %0d want 0", pwm_cnt); end
    k = 0;
    for (int i = 0; i < 1300 && k < 256; i++) begin
      @(negedge clk);
      if (led_valid && led_ready) begin
        checks++;
        if (pwm_cnt !== 8'(k) || led_bits[0] !== (k < 3) || led_bits[39] !== (k != 255) || led_bits[5] !== 1'b0) begin
          errors++;
          $display("FAIL swap_duty_bits slot %0d got cnt %0d b0 %b b39 %b b5 %b want b0 %b b39 %b b5 0",
                   k, pwm_cnt, led_bits[0], led_bits[39], led_bits[5], k < 3, k != 255);
        end
        k++;
      end
    end
    checks++; if (k != 256) begin errors++; $display("FAIL swap_period_slots got %0d want 256", k); end
  endtask

  task automatic test_stall();
    bit found;
    logic [39:0] rb;
    logic [7:0] rc;
    led_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (led_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_valid_seen got 0 want 1"); end
    rb = led_bits;
    rc = pwm_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (led_valid !== 1'b1 || led_bits !== rb || pwm_cnt !== rc) begin
        errors++;
        $display("FAIL stall_stable got v %b bits %h cnt %0d want v 1 bits %h cnt %0d", led_valid, led_bits, pwm_cnt, rb, rc);
      end
    end
    led_ready = 1'b1;
    @(negedge clk);
    checks++; if (led_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_drop got %b want 0", led_valid); end
  endtask

  task automatic test_bad_addr();
    bit found;
    int k;
    do_write(40, 255);
    do_write(63, 255);
    pulse_swap();
    wait_swap_done(found);
    checks++; if (!found) begin errors++; $display("FAIL badaddr_swap_seen got 0 want 1"); end
    k = 0;
    for (int i = 0; i < 1300 && k < 256; i++) begin
      @(negedge clk);
      if (led_valid && led_ready) begin
        checks++;
        if (led_bits !== model_bits(k)) begin
          errors++;
          $display("FAIL badaddr_bits slot %0d got %h want %h", k, led_bits, model_bits(k));
        end
        k++;
      end
    end
    checks++; if (k != 256) begin errors++; $display("FAIL badaddr_period_slots got %0d want 256", k); end
  endtask

  task automatic test_back_to_back();
    bit found;
    int old_v, new_v, ones, slots;
    old_v = int'($urandom_range(50, 200));
    new_v = int'($urandom_range(1, 40));
    do_write(1, old_v);
    found = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      if (cd_m == 1 && !pending_m) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_wrap_found got 0 want 1"); end
    frame_swap = 1'b1;
    wr_en = 1'b1;
    wr_addr = 6'd1;
    wr_data = 8'(new_v);
    @(negedge clk);
    frame_swap = 1'b0;
    wr_en = 1'b0;
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL b2b_swap_done got %b want 1", swap_done); end
    checks++; if (pwm_cnt !== 8'd0) begin errors++; $display("FAIL b2b_cnt got %0d want 0", pwm_cnt); end
    collect_ones(1, ones, slots);
    checks++; if (ones != old_v || slots != 256) begin errors++; $display("FAIL b2b_old_duty got %0d/%0d want %0d/256", ones, slots, old_v); end
    pulse_swap();
    wait_swap_done(found);
    checks++; if (!found) begin errors++; $display("FAIL b2b_second_swap got 0 want 1"); end
    collect_ones(1, ones, slots);
    checks++; if (ones != new_v || slots != 256) begin errors++; $display("FAIL b2b_new_duty got %0d/%0d want %0d/256", ones, slots, new_v); end
  endtask

  task automatic test_abort();
    bit found;
    logic [7:0] rc;
    int nz;
    led_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (led_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_valid_seen got 0 want 1"); end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led_valid !== 1'b1) begin errors++; $display("FAIL abort_valid_held got %b want 1", led_valid); end
    rc = pwm_cnt + 8'd1;
    led_ready = 1'b1;
    repeat (SD + 2) @(negedge clk);
    checks++; if (pwm_cnt !== rc || led_valid !== 1'b0) begin errors++; $display("FAIL abort_to_idle got cnt %0d v %b want cnt %0d v 0", pwm_cnt, led_valid, rc); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_cnt !== rc || led_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_frozen got cnt %0d v %b want cnt %0d v 0", pwm_cnt, led_valid, rc); end
    end
    do_write(2, 200);
    pulse_swap();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_resume_valid got 0 want 1"); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (led_bits !== '0 || led_valid !== 1'b0 || pwm_cnt !== '0 || swap_done !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got bits %h v %b cnt %0d sd %b ps %b want all 0", led_bits, led_valid, pwm_cnt, swap_done, period_start);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (period_start !== 1'b1 || pwm_cnt !== 8'd0) begin errors++; $display("FAIL post_reset_start got ps %b cnt %0d want ps 1 cnt 0", period_start, pwm_cnt); end
    nz = 0;
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (swap_done === 1'b1) found = 1'b1;
      if (led_valid && led_bits !== '0) nz++;
    end
    checks++; if (found) begin errors++; $display("FAIL post_reset_pending got swap_done 1 want 0"); end
    checks++; if (nz != 0) begin errors++; $display("FAIL post_reset_banks got %0d lit slots want 0", nz); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_swap();
    test_stall();
    test_bad_addr();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
